// File: rtl/ms_uart_pkg.sv
// ms_uart_pkg: definitions shared by the parametrised UART receiver and the
// future parametrised transmitter.
//   parity_e    : parity mode encoding (matches the PARITY_MODE parameter)
//   rx_state_e  : receiver FSM states
//   SYNC_STAGES : depth of the RXD metastability synchroniser
//   maj3        : 2-of-3 majority helper used by the optional vote sampler
package ms_uart_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ms_uart_baud_tick.sv
// ms_uart_baud_tick: runtime-programmable baud tick generator.
// A counter runs 0..div and emits a one-cycle tick when it equals div, then
// wraps to 0. div=0 ticks every cycle. A new div is picked up naturally at the
// next wrap; if div is lowered below the current count, the counter wraps at
// once without a tick.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   div  : tick period minus one, in clk cycles
//   tick : one-cycle pulse, once per (div+1) cycles
module ms_uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + DIV_W'(1);
    if (cnt_q >= div) begin
      tick  = (cnt_q == div);
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ms_uart_rx_param.sv
// ms_uart_rx_param: parametrised UART receiver (configurable data width,
// oversampling, parity and stop bits) with a valid/ready holding register.
// Optional build macro: MS_UART_RX_MAJORITY_EN -- when defined every bit is a
// 2-of-3 majority vote around the bit centre instead of a single sample.
// Ports:
//   CLK    : system clock (single domain)
//   RESETN : asynchronous reset, active-high despite its name
//   DIV    : baud tick period minus one, in CLK cycles
//   RXD    : asynchronous serial input, idle high
//   READY  : consumer accepts the held frame
//   DOUT   : received payload
//   VALID  : DOUT/PERR/FERR hold a fresh frame
//   PERR   : parity mismatch of the held frame
//   FERR   : a stop bit of the held frame sampled low
//   OVR    : one-cycle pulse, a completed frame was dropped
//   BUSY   : receiver FSM not idle
// Handshake: a frame is transferred on any cycle with VALID=1 and READY=1;
// VALID stays high and DOUT/PERR/FERR stay stable until that happens. A frame
// completing while VALID=1 and READY=0 is dropped (OVR pulses); a frame
// completing in the accept cycle replaces the old one and VALID stays high.
module ms_uart_rx_param
  import ms_uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int DIV_W       = 16
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [DIV_W-1:0]     DIV,
  input  logic                 RXD,
  input  logic                 READY,
  output logic [DATA_BITS-1:0] DOUT,
  output logic                 VALID,
  output logic                 PERR,
  output logic                 FERR,
  output logic                 OVR,
  output logic                 BUSY
);

  localparam int SC_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [SC_W-1:0]  SC_LAST    = SC_W'(OVERSAMPLE - 1);
  localparam logic [SC_W-1:0]  SC_HALF_M1 = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST  = (STOP_BITS == 2);
  localparam parity_e PMODE = (PARITY_MODE == 1) ? PAR_EVEN :
                              (PARITY_MODE == 2) ? PAR_ODD  : PAR_NONE;

  logic tick;

  ms_uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
    .clk  (CLK),
    .rst  (RESETN),
    .div  (DIV),
    .tick (tick)
  );

  // RXD synchroniser; idles high so reset does not look like a start bit.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   rxs;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], RXD};
  assign rxs    = sync_q[SYNC_STAGES-1];

  rx_state_e            state_q, state_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_p_q, perr_p_d;
  logic                 ferr_p_q, ferr_p_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 complete;
  logic                 bit_s;
  logic                 start_s;
  logic                 exp_par;

`ifdef MS_UART_RX_MAJORITY_EN
  localparam logic [SC_W-1:0] SC_MID    = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_MID_M2 = SC_W'(OVERSAMPLE / 2 - 2);
  localparam logic [SC_W-1:0] SC_MID_M3 = SC_W'(OVERSAMPLE / 2 - 3);

  logic [1:0] vote_q, vote_d;
  logic       maj_q, maj_d;

  // Data/parity/stop bits vote over MID-2..MID and hold the result until the
  // bit is consumed at SC_LAST. The start bit votes over the three ticks
  // ending at its decision point so frame timing matches the single-sample
  // build.
  always_comb begin
    vote_d = vote_q;
    maj_d  = maj_q;
    if (tick && (state_q != IDLE)) begin
      if (state_q == START) begin
        if (sc_q == SC_MID_M3) vote_d[0] = rxs;
        if (sc_q == SC_MID_M2) vote_d[1] = rxs;
      end else begin
        if (sc_q == SC_MID_M2) vote_d[0] = rxs;
        if (sc_q == SC_HALF_M1) vote_d[1] = rxs;
        if (sc_q == SC_MID) maj_d = maj3(vote_q[0], vote_q[1], rxs);
      end
    end
  end

  assign bit_s   = maj_q;
  assign start_s = maj3(vote_q[0], vote_q[1], rxs);
`else
  assign bit_s   = rxs;
  assign start_s = rxs;
`endif

  assign exp_par = (PMODE == PAR_ODD) ? ~^shift_q : ^shift_q;

  // Receiver FSM: next state and per-frame datapath.
  always_comb begin
    state_d    = state_q;
    sc_d       = sc_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    perr_p_d   = perr_p_q;
    ferr_p_d   = ferr_p_q;
    complete   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            sc_d    = '0;
          end
        end
        START: begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == SC_HALF_M1) begin
            sc_d = '0;
            if (start_s) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              idx_d      = '0;
              stop_idx_d = 1'b0;
              perr_p_d   = 1'b0;
              ferr_p_d   = 1'b0;
            end
          end
        end
        DATA: begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == SC_LAST) begin
            sc_d           = '0;
            shift_d[idx_q] = bit_s;
            if (idx_q == IDX_LAST) state_d = (PMODE == PAR_NONE) ? STOP : PARITY;
            else                   idx_d   = idx_q + IDX_W'(1);
          end
        end
        PARITY: begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == SC_LAST) begin
            sc_d     = '0;
            perr_p_d = (bit_s != exp_par);
            state_d  = STOP;
          end
        end
        STOP: begin
          sc_d = sc_q + SC_W'(1);
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            if (!bit_s) ferr_p_d = 1'b1;
            if (stop_idx_q == STOP_LAST) begin
              complete = 1'b1;
              state_d  = IDLE;
            end else begin
              stop_idx_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Holding register and overrun detection.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (complete) begin
      if (valid_q && !READY) begin
        ovr_d = 1'b1;
      end else begin
        dout_d  = shift_q;
        perr_d  = perr_p_d;
        ferr_d  = ferr_p_d;
        valid_d = 1'b1;
      end
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      sync_q     <= '1;
      state_q    <= IDLE;
      sc_q       <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_p_q   <= 1'b0;
      ferr_p_q   <= 1'b0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef MS_UART_RX_MAJORITY_EN
      vote_q     <= 2'b11;
      maj_q      <= 1'b1;
`endif
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      sc_q       <= sc_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      perr_p_q   <= perr_p_d;
      ferr_p_q   <= ferr_p_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef MS_UART_RX_MAJORITY_EN
      vote_q     <= vote_d;
      maj_q      <= maj_d;
`endif
    end
  end

  assign DOUT  = dout_q;
  assign VALID = valid_q;
  assign PERR  = perr_q;
  assign FERR  = ferr_q;
  assign OVR   = ovr_q;
  assign BUSY  = (state_q != IDLE);

endmodule
